// File: rtl/dec_scan_ctrl.sv
// dec_scan_ctrl: time-multiplexed scan controller for a 3-to-8 active-low decoder.
// Rev 1.0 - dwell/blanking scan over a masked channel subset.
`default_nettype none

module dec_scan_ctrl #(
  parameter int DWELL_W   = 16,
  parameter int BLANK_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [7:0]         mask_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic               sel_a_o,
  output logic               sel_b_o,
  output logic               sel_c_o,
  output logic [7:0]         y_n_o,
  output logic [2:0]         ch_o,
  output logic               ch_valid_o,
  output logic               frame_done_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BLANK  = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  localparam bit         HAS_BLANK  = (BLANK_CYC > 0);
  localparam logic [7:0] BLANK_LOAD = HAS_BLANK ? 8'(BLANK_CYC - 1) : 8'd0;

  logic [1:0]         state_q, state_d;
  logic [2:0]         ch_q, ch_d;
  logic [2:0]         sel_q, sel_d;
  logic [7:0]         y_n_q, y_n_d;
  logic               ch_valid_q, ch_valid_d;
  logic               frame_done_q, frame_done_d;
  logic [7:0]         blank_cnt_q, blank_cnt_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;

  logic               go;
  logic [2:0]         first_ch;
  logic [2:0]         next_ch;
  logic [DWELL_W-1:0] dwell_load;

  function automatic logic [2:0] f_first(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (m[k]) r = 3'(k);
    end
    return r;
  endfunction

  // Lowest set bit above c; falls back to the lowest set bit overall (wrap).
  function automatic logic [2:0] f_next(input logic [7:0] m, input logic [2:0] c);
    logic [2:0] r;
    r = f_first(m);
    for (int k = 7; k >= 0; k--) begin
      if (m[k] && (k > int'(c))) r = 3'(k);
    end
    return r;
  endfunction

  assign go         = en_i && (mask_i != 8'h00);
  assign first_ch   = f_first(mask_i);
  assign next_ch    = f_next(mask_i, ch_q);
  // Counter holds remaining cycles minus one, so a dwell of 0 behaves as 1.
  assign dwell_load = (dwell_i == '0) ? '0 : dwell_i - DWELL_W'(1);

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    blank_cnt_d  = blank_cnt_q;
    dwell_cnt_d  = dwell_cnt_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          ch_d = first_ch;
          if (HAS_BLANK) begin
            state_d     = S_BLANK;
            blank_cnt_d = BLANK_LOAD;
          end else begin
            state_d     = S_ACTIVE;
            dwell_cnt_d = dwell_load;
          end
        end
      end
      S_BLANK: begin
        if (!go) begin
          state_d = S_IDLE;
        end else if (blank_cnt_q == 8'd0) begin
          state_d     = S_ACTIVE;
          dwell_cnt_d = dwell_load;
        end else begin
          blank_cnt_d = blank_cnt_q - 8'd1;
        end
      end
      S_ACTIVE: begin
        if (!go) begin
          state_d = S_IDLE;
        end else if (dwell_cnt_q == '0) begin
          ch_d         = next_ch;
          frame_done_d = (next_ch <= ch_q);
          if (HAS_BLANK) begin
            state_d     = S_BLANK;
            blank_cnt_d = BLANK_LOAD;
          end else begin
            dwell_cnt_d = dwell_load;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Decoder asserts output k when {A,B,C} == ~k; one-hot is gated outside ACTIVE.
    sel_d      = ~ch_d;
    ch_valid_d = (state_d == S_ACTIVE);
    y_n_d      = ch_valid_d ? ~(8'b1 << ch_d) : 8'hFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ch_q         <= 3'd0;
      sel_q        <= 3'b111;
      y_n_q        <= 8'hFF;
      ch_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      blank_cnt_q  <= 8'd0;
      dwell_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      sel_q        <= sel_d;
      y_n_q        <= y_n_d;
      ch_valid_q   <= ch_valid_d;
      frame_done_q <= frame_done_d;
      blank_cnt_q  <= blank_cnt_d;
      dwell_cnt_q  <= dwell_cnt_d;
    end
  end

  assign sel_a_o      = sel_q[2];
  assign sel_b_o      = sel_q[1];
  assign sel_c_o      = sel_q[0];
  assign y_n_o        = y_n_q;
  assign ch_o         = ch_q;
  assign ch_valid_o   = ch_valid_q;
  assign frame_done_o = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_dec_scan_ctrl.sv
// tb_dec_scan_ctrl: directed self-checking bench for dec_scan_ctrl (BLANK_CYC=4 and BLANK_CYC=0 builds).
`default_nettype none

module tb_dec_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic [7:0]  mask;
  logic [15:0] dwell;

  logic       sa4, sb4, sc4, vld4, fd4;
  logic [7:0] yn4;
  logic [2:0] ch4;
  logic       sa0, sb0, sc0, vld0, fd0;
  logic [7:0] yn0;
  logic [2:0] ch0;

  int checks   = 0;
  int failures = 0;

  dec_scan_ctrl #(.DWELL_W(16), .BLANK_CYC(4)) dut4 (
    .clk(clk), .rst(rst), .en_i(en), .mask_i(mask), .dwell_i(dwell),
    .sel_a_o(sa4), .sel_b_o(sb4), .sel_c_o(sc4), .y_n_o(yn4), .ch_o(ch4),
    .ch_valid_o(vld4), .frame_done_o(fd4)
  );

  dec_scan_ctrl #(.DWELL_W(16), .BLANK_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .en_i(en), .mask_i(mask), .dwell_i(dwell),
    .sel_a_o(sa0), .sel_b_o(sb0), .sel_c_o(sc0), .y_n_o(yn0), .ch_o(ch0),
    .ch_valid_o(vld0), .frame_done_o(fd0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all4(input string tag, input logic [7:0] e_yn, input logic [2:0] e_ch,
                          input logic e_vld, input logic e_fd);
    logic [2:0] e_sel;
    e_sel = ~e_ch;
    chk({tag, "_yn"},  16'(yn4), 16'(e_yn));
    chk({tag, "_ch"},  16'(ch4), 16'(e_ch));
    chk({tag, "_sel"}, 16'({sa4, sb4, sc4}), 16'(e_sel));
    chk({tag, "_vld"}, 16'(vld4), 16'(e_vld));
    chk({tag, "_fd"},  16'(fd4), 16'(e_fd));
  endtask

  task automatic do_blank(input int c, input int n, input logic fd_first);
    for (int i = 0; i < n; i++) begin
      step();
      chk_all4($sformatf("blank_c%0d_%0d", c, i), 8'hFF, 3'(c), 1'b0, (i == 0) ? fd_first : 1'b0);
    end
  endtask

  task automatic do_active(input int c, input int n, input logic fd_first);
    logic [7:0] e_yn;
    e_yn = ~(8'b1 << c);
    for (int i = 0; i < n; i++) begin
      step();
      chk_all4($sformatf("act_c%0d_%0d", c, i), e_yn, 3'(c), 1'b1, (i == 0) ? fd_first : 1'b0);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; mask = 8'h00; dwell = 16'd0;
    #2 rst = 1'b1;
    step();
    step();
    chk_all4("reset", 8'hFF, 3'd0, 1'b0, 1'b0);
    chk("reset0_yn", 16'(yn0), 16'h00FF);
    chk("reset0_sel", 16'({sa0, sb0, sc0}), 16'h0007);

    // Full 8-channel scan, dwell 3.
    rst = 1'b0; en = 1'b1; mask = 8'hFF; dwell = 16'd3;
    for (int c = 0; c < 8; c++) begin
      do_blank(c, 4, 1'b0);
      do_active(c, 3, 1'b0);
    end
    do_blank(0, 4, 1'b1);
    do_active(0, 3, 1'b0);
    en = 1'b0;
    step();
    chk_all4("idle1", 8'hFF, 3'd0, 1'b0, 1'b0);

    // Sparse mask 2,5,7.
    mask = 8'b1010_0100; dwell = 16'd2; en = 1'b1;
    do_blank(2, 4, 1'b0); do_active(2, 2, 1'b0);
    do_blank(5, 4, 1'b0); do_active(5, 2, 1'b0);
    do_blank(7, 4, 1'b0); do_active(7, 2, 1'b0);
    do_blank(2, 4, 1'b1); do_active(2, 2, 1'b0);
    do_blank(5, 4, 1'b0);
    en = 1'b0;
    step();
    chk_all4("idle2", 8'hFF, 3'd5, 1'b0, 1'b0);

    // Single channel, dwell 0 treated as 1: frame_done every 5 cycles.
    mask = 8'h10; dwell = 16'd0; en = 1'b1;
    do_blank(4, 4, 1'b0); do_active(4, 1, 1'b0);
    for (int r = 0; r < 3; r++) begin
      do_blank(4, 4, 1'b1);
      do_active(4, 1, 1'b0);
    end
    en = 1'b0;
    step();
    chk_all4("idle3", 8'hFF, 3'd4, 1'b0, 1'b0);

    // Clear bit 3 while ch3 is mid-dwell.
    mask = 8'hFF; dwell = 16'd3; en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      do_blank(c, 4, 1'b0);
      do_active(c, 3, 1'b0);
    end
    do_blank(3, 4, 1'b0);
    do_active(3, 1, 1'b0);
    mask = 8'hF7;
    do_active(3, 2, 1'b0);
    for (int c = 4; c < 8; c++) begin
      do_blank(c, 4, 1'b0);
      do_active(c, 3, 1'b0);
    end
    do_blank(0, 4, 1'b1); do_active(0, 3, 1'b0);
    do_blank(1, 4, 1'b0); do_active(1, 3, 1'b0);
    do_blank(2, 4, 1'b0); do_active(2, 3, 1'b0);
    do_blank(4, 4, 1'b0); do_active(4, 3, 1'b0);

    // Drop en in the 2nd ACTIVE cycle of ch5.
    do_blank(5, 4, 1'b0);
    do_active(5, 2, 1'b0);
    en = 1'b0;
    step();
    chk_all4("drop_en", 8'hFF, 3'd5, 1'b0, 1'b0);
    step();
    chk_all4("drop_en_hold", 8'hFF, 3'd5, 1'b0, 1'b0);

    // Re-enable restarts at lowest set bit of F7.
    en = 1'b1;
    do_blank(0, 4, 1'b0); do_active(0, 3, 1'b0);
    do_blank(1, 4, 1'b0); do_active(1, 1, 1'b0);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    chk_all4("async_rst", 8'hFF, 3'd0, 1'b0, 1'b0);
    step();
    chk_all4("rst_hold", 8'hFF, 3'd0, 1'b0, 1'b0);

    // BLANK_CYC=0 build alternates ch0/ch1 with no gap.
    rst = 1'b0; mask = 8'h03; dwell = 16'd1; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("nb_yn_%0d", i), 16'(yn0), (i % 2 == 0) ? 16'h00FE : 16'h00FD);
      chk($sformatf("nb_ch_%0d", i), 16'(ch0), 16'(i % 2));
      chk($sformatf("nb_vld_%0d", i), 16'(vld0), 16'd1);
      chk($sformatf("nb_fd_%0d", i), 16'(fd0), (i > 0 && i % 2 == 0) ? 16'd1 : 16'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dec_scan_ctrl.md
Name: dec_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 3-to-8 active-low decoder.
- Steps through a programmable subset of the 8 decoder channels.
- For each channel it drives the decoder select inputs A/B/C, holds the channel for a programmable dwell time, and inserts a blanking gap between channels to prevent ghosting on the shared lines.
- Sits between the register/config logic and the decoder. It also drives an equivalent registered active-low one-hot output so the selection can be gated during blanking.

Parameters:
- DWELL_W, 16, width of the dwell-count input.
- BLANK_CYC, 4, blanking cycles inserted before each channel (0..255; 0 means no blanking state).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- en  in  1  scan enable (level).
- mask  in  8  channel enable mask; bit k enables channel k.
- dwell  in  DWELL_W  active cycles per channel; 0 is treated as 1.
- sel_a  out  1  decoder select A (MSB).
- sel_b  out  1  decoder select B.
- sel_c  out  1  decoder select C (LSB).
- y_n  out  8  gated active-low one-hot of the current channel; 8'hFF when not ACTIVE.
- ch  out  3  current channel index.
- ch_valid  out  1  high while in ACTIVE.
- frame_done  out  1  one-cycle pulse at the end of the last channel of a scan pass.

Behaviour:
- All outputs are registered.
- Reset values, asynchronous: state=IDLE, ch=0, {sel_a,sel_b,sel_c}=3'b111, y_n=8'hFF, ch_valid=0, frame_done=0, counters=0.
- Decoder polarity: the decoder pulls output k low when {A,B,C} = ~k. The block therefore always drives {sel_a,sel_b,sel_c} = ~ch, updated on the same edge as ch.
- "Go" condition: go = en && (mask != 0).
- "Next(c)": lowest set bit of mask at index > c. If none exists, wrap to the lowest set bit overall, which may be c itself.

States:
- IDLE
  - y_n=FF, ch_valid=0.
  - On go: ch <= lowest set bit of mask, searching from index 0.
  - If BLANK_CYC > 0: load the blank counter and go to BLANK. Otherwise load dwell and go to ACTIVE.
- BLANK
  - y_n=FF, ch_valid=0; sel already shows the new channel.
  - Lasts exactly BLANK_CYC cycles, then load dwell (0 becomes 1) and go to ACTIVE.
- ACTIVE
  - y_n = ~(8'b1 << ch), ch_valid=1.
  - Lasts exactly max(dwell,1) cycles, with dwell sampled on ACTIVE entry.
  - On the final cycle: ch <= Next(ch) and enter BLANK (or re-enter ACTIVE if BLANK_CYC=0).
  - frame_done=1 for the cycle after that edge if Next(ch) <= ch, i.e. the scan wrapped.

Boundary conditions:
- Latency: if go is first sampled high at edge N, sel is valid from N, and ACTIVE starts at edge N+BLANK_CYC.
- go low at any edge in BLANK/ACTIVE: go to IDLE on that edge. y_n=FF and ch_valid=0 from that edge; ch/sel hold their last value. No frame_done.
- mask changes during ACTIVE: the current dwell completes even if its own bit was cleared. The new mask is used only for Next().
- mask changes during BLANK: no effect on the channel already chosen.
- Single-channel mask: the channel repeats, with BLANK between repetitions. frame_done pulses every pass.
- dwell changes mid-channel: no effect until the next ACTIVE entry.
- Re-enable from IDLE: always restarts at the lowest set bit, not at the previous ch.
- Reset mid-operation: immediate return to reset values; no glitch pulse on frame_done.

Test Plan:
- Reset, then BLANK_CYC=4, dwell=3, mask=8'hFF, en=1.
  - -> Channels 0..7 in order; 4 cycles of y_n=FF, then 3 cycles of y_n=FE, FD, ... 7F.
  - -> {a,b,c}=111 for ch0, 000 for ch7.
  - -> frame_done pulses once per 56-cycle pass, right after ch7.
- mask=8'b10100100, dwell=2.
  - -> Sequence 2,5,7,2,...; y_n=FB, DF, 7F during ACTIVE.
  - -> frame_done after each ch7.
- mask=8'h10, dwell=0.
  - -> Channel 4 only; ACTIVE 1 cycle, y_n=EF, sel=011.
  - -> frame_done every 5 cycles.
- Clear bit 3 mid-dwell of ch3 (mask FF→F7).
  - -> ch3 finishes its full dwell; next channel is 4; ch3 is skipped on later passes.
- Drop en in the 2nd ACTIVE cycle of ch5.
  - -> Next edge: IDLE, y_n=FF, ch_valid=0, sel holds 010.
  - -> Re-assert en: restart at the lowest set bit after BLANK_CYC.
- Assert rst asynchronously mid-ACTIVE (between clock edges).
  - -> Outputs go to reset values immediately, before the next edge: y_n=FF, sel=111, frame_done=0.
- BLANK_CYC=0 build, mask=8'h03, dwell=1.
  - -> y_n alternates FE, FD every cycle with no FF gap.
